ss_iter_mul: RTL and testbench

Iterative shift-add unsigned multiplier that sits directly downstream of `SS_detect_start`. It consumes the `o_w_start` strobe as its launch request and multiplies two latched operands over multiple cycles. When finished it returns a one-cycle `o_done` pulse, which drives the upstream `i_done` input and re-arms the start detector. It is the first compute stage of the SS datapath.

---
 rtl/ss_iter_mul.sv | 116 +++++++++++
 tb/tb_ss_iter_mul.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ss_iter_mul.sv
// Iterative shift-add unsigned multiplier launched by the SS start detector.
// Optional early exit on a zero multiplier: define SS_ITER_MUL_EARLY_EXIT_EN.
module ss_iter_mul #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_w_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_result
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PROD_W-1:0]   result_q, result_d;
  logic                last_iter;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Next-state, one shift-add iteration per RUN cycle
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    last_iter = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_w_start) begin
          mcand_d  = PROD_W'(i_a);
          mplier_d = i_b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        last_iter = (cnt_q == CNT_W'(DATA_W - 1));
`ifdef SS_ITER_MUL_EARLY_EXIT_EN
        // No set bits left in the multiplier: the accumulator is already final.
        if (mplier_d == '0) begin
          last_iter = 1'b1;
        end
`endif
        if (last_iter) begin
          result_d = acc_d;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_ss_iter_mul.sv
// Scoreboard bench for ss_iter_mul (DATA_W=8): random and corner operands
// checked against a plain-arithmetic reference, including result and latency.
module tb_ss_iter_mul;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;

  logic          clk;
  logic          rst_n;
  logic          w_start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          busy;
  logic          done;
  logic [PW-1:0] result;

  typedef struct {
    logic [PW-1:0] res;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [PW-1:0] prev_res = '0;

  ss_iter_mul #(.DATA_W(DW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_w_start (w_start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (busy),
    .o_done    (done),
    .o_result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference latency: full width, or up to the multiplier's top set bit.
  function automatic int lat_of(input logic [DW-1:0] bv);
    int l;
    l = DW;
`ifdef SS_ITER_MUL_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < DW; i++) if (bv[i]) l = i + 1;
`endif
    return l;
  endfunction

  // Launch one operation; the accepting edge is the next rising edge.
  task automatic launch(input logic [DW-1:0] av, input logic [DW-1:0] bv, input bit push);
    exp_t e;
    @(negedge clk);
    w_start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    w_start = 1'b0;
    a = DW'($urandom);
    b = DW'($urandom);
    check("busy_after_launch", int'(busy), 1);
    if (push) begin
      e.res = PW'(int'(av) * int'(bv));
      e.due = cyc + lat_of(bv);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  // Monitor: pop and compare on every completion pulse; result must hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_res = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", int'(result), int'(e.res));
        check("done_cycle", cyc, e.due);
        check("busy_with_done", int'(busy), 1);
      end
      prev_res = result;
    end else if (result != prev_res) begin
      check("result_stable", int'(result), int'(prev_res));
      prev_res = result;
    end
  end

  initial begin
    logic [DW-1:0] b_busy;
    rst_n   = 1'b0;
    w_start = 1'b0;
    a       = '0;
    b       = '0;

    // Reset with random inputs toggling
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      w_start = 1'($urandom);
      a = DW'($urandom);
      b = DW'($urandom);
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
    end
    w_start = 1'b0;
    rst_n = 1'b1;

    launch(8'd13, 8'd11, 1'b1);  wait_idle();
    launch(8'd255, 8'd255, 1'b1); wait_idle();
    launch(8'd0, 8'd200, 1'b1);  wait_idle();
    launch(8'd1, 8'd77, 1'b1);   wait_idle();
    launch(8'd9, 8'd3, 1'b1);    wait_idle();
    launch(8'd5, 8'd0, 1'b1);    wait_idle();
    launch(8'd200, 8'd1, 1'b1);  wait_idle();

    // Start pulses and operand changes while busy must be ignored
`ifdef SS_ITER_MUL_EARLY_EXIT_EN
    b_busy = 8'd139;
`else
    b_busy = 8'd11;
`endif
    launch(8'd13, b_busy, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    w_start = 1'b1; a = DW'($urandom); b = DW'($urandom);
    @(posedge clk); #1; w_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    w_start = 1'b1; a = DW'($urandom); b = DW'($urandom);
    @(posedge clk); #1; w_start = 1'b0;
    check("busy_mid_run", int'(busy), 1);
    wait_idle();
    repeat (3) @(negedge clk);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      launch(DW'($urandom), DW'($urandom), 1'b1);
      wait_idle();
    end

    // Reset mid-run: aborted operation must not complete
    launch(8'd13, 8'd255, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", int'(done), 0);
    launch(8'd6, 8'd7, 1'b1);
    wait_idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
